// File: rtl/irq_controller.sv
// Interrupt request controller: synchronizes NUM_SRC external lines, latches rising
// edges as pending, grants by fixed priority (lowest index wins) and enforces a hold-off.
module irq_controller #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         irq_in,
    input  logic                       global_en,
    input  logic                       mask_we,
    input  logic [NUM_SRC-1:0]         mask_wdata,
    output logic                       int_out,
    output logic [$clog2(NUM_SRC)-1:0] int_id,
    output logic [NUM_SRC-1:0]         pending,
    output logic [NUM_SRC-1:0]         mask,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_SRC);
    localparam int CW  = $clog2(HOLDOFF + 1);

    // state | meaning
    // IDLE  | waiting for an eligible request while global_en is set
    // HOLD  | hold-off after a grant; cnt counts down to 0, no grants
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               int_out_q;
    logic [IDW-1:0]     int_id_q;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s_d_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr;
    logic [IDW-1:0]     win;
    logic               grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~s_d_q;
    assign elig     = pending_q & ~mask_q;
    assign grant    = (state_q == IDLE) && global_en && (|elig);

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win = IDW'(i);
        end
    end

    always_comb begin
        clr = '0;
        if (grant) clr[win] = 1'b1;
    end

    // A new edge on the bit being granted survives the clear.
    assign pending_d = (pending_q & ~clr) | edge_det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            int_out_q <= 1'b0;
            int_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    int_out_q <= 1'b0;
                    if (grant) begin
                        int_out_q <= 1'b1;
                        int_id_q  <= win;
                        cnt_q     <= CW'(HOLDOFF);
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    int_out_q <= 1'b0;
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign int_out = int_out_q;
    assign int_id  = int_id_q;
    assign pending = pending_q;
    assign mask    = mask_q;
    assign busy    = (state_q == HOLD);

endmodule
